// File: rtl/acc_differencer.sv
// Recovers per-cycle addends from a stream of accumulated values and
// queues them in a small output FIFO with valid/ready on both sides.
module acc_differencer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    input  logic                            in_first,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_first,
    output logic                            out_borrow,
    output logic [$clog2(FIFO_DEPTH):0]     level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic             first;
        logic             borrow;
        logic [WIDTH-1:0] diff;
    } entry_t;

    typedef enum logic {
        NO_PREV   = 1'b0,
        HAVE_PREV = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   prev;
    logic [WIDTH-1:0]   prev_nxt;
    entry_t             push_entry;
    logic [WIDTH:0]     sub_c;

    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    entry_t             head_c;

    logic               accept;
    logic               pop;

    // Handshake qualification; in_ready depends only on stored occupancy
    assign in_ready  = (level != LVL_W'(FIFO_DEPTH));
    assign out_valid = (level != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // State and previous-value register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= NO_PREV;
            prev  <= '0;
        end else begin
            state <= state_nxt;
            prev  <= prev_nxt;
        end
    end

    // Next state and entry to push; subtraction carries one extra bit for borrow
    always_comb begin
        state_nxt  = state;
        prev_nxt   = prev;
        push_entry = '0;
        sub_c      = {1'b0, in_data} - {1'b0, prev};
        if (accept) begin
            prev_nxt = in_data;
            if ((state == NO_PREV) || in_first) begin
                push_entry.first  = 1'b1;
                push_entry.borrow = 1'b0;
                push_entry.diff   = in_data;
                state_nxt         = HAVE_PREV;
            end else begin
                push_entry.first  = 1'b0;
                push_entry.borrow = sub_c[WIDTH];
                push_entry.diff   = sub_c[WIDTH-1:0];
            end
        end
    end

    // FIFO storage; contents need no reset since outputs are gated by out_valid
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Head entry, forced to zero while the FIFO is empty
    assign head_c     = mem[rd_ptr];
    assign out_data   = out_valid ? head_c.diff   : '0;
    assign out_first  = out_valid ? head_c.first  : 1'b0;
    assign out_borrow = out_valid ? head_c.borrow : 1'b0;

endmodule

// File: tb/tb_acc_differencer.sv
// Randomized and directed bench for acc_differencer against a queue model.
module tb_acc_differencer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_first = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_first;
    logic             out_borrow;
    logic [2:0]       level;

    acc_differencer #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_first   (in_first),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_first  (out_first),
        .out_borrow (out_borrow),
        .level      (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit first;
        bit borrow;
    } exp_t;

    exp_t q[$];
    bit   m_has_prev = 1'b0;
    int   m_prev = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // Count one comparison and report a mismatch
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Compare every observable output with the model's view
    task automatic check_outputs(input string tag);
        int sz;
        sz = q.size();
        check({tag, ".out_valid"}, 32'(out_valid), 32'(sz != 0));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(sz != int'(DEPTH)));
        check({tag, ".level"}, 32'(level), 32'(sz));
        check({tag, ".out_data"}, 32'(out_data), (sz != 0) ? 32'(q[0].data) : 32'd0);
        check({tag, ".out_first"}, 32'(out_first), (sz != 0) ? 32'(q[0].first) : 32'd0);
        check({tag, ".out_borrow"}, 32'(out_borrow), (sz != 0) ? 32'(q[0].borrow) : 32'd0);
    endtask

    task automatic model_reset();
        q.delete();
        m_has_prev = 1'b0;
        m_prev = 0;
    endtask

    // Drive one cycle of inputs (called just after a falling edge), update model at the
    // rising edge, then check at the next falling edge
    task automatic step(input bit v, input int d, input bit f, input bit r, input string tag);
        bit   acc;
        bit   pp;
        exp_t e;
        in_valid  = v;
        in_data   = WIDTH'(d);
        in_first  = f;
        out_ready = r;
        @(posedge clk);
        acc = v && (q.size() != int'(DEPTH));
        pp  = r && (q.size() != 0);
        if (pp) void'(q.pop_front());
        if (acc) begin
            if (!m_has_prev || f) begin
                e.data = d; e.first = 1'b1; e.borrow = 1'b0;
            end else begin
                e.data   = ((d - m_prev) % 256 + 256) % 256;
                e.first  = 1'b0;
                e.borrow = d < m_prev;
            end
            q.push_back(e);
            m_prev = d;
            m_has_prev = 1'b1;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        // 1: reset held two cycles, then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data", 32'(out_data), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.level", 32'(level), 32'd0);
        reset = 1'b0;
        model_reset();
        repeat (3) step(1'b0, 0, 1'b0, 1'b0, "idle");

        // 2: simple run with consumer always ready
        step(1'b1, 5, 1'b1, 1'b1, "run5");
        check("run5.const", 32'(out_data), 32'd5);
        step(1'b1, 12, 1'b0, 1'b1, "run12");
        check("run12.const", 32'(out_data), 32'd7);
        step(1'b1, 30, 1'b0, 1'b1, "run30");
        check("run30.const", 32'(out_data), 32'd18);
        step(1'b0, 0, 1'b0, 1'b1, "drain2");

        // 3: wrap-around with borrow
        step(1'b1, 250, 1'b1, 1'b1, "wrap250");
        step(1'b1, 4, 1'b0, 1'b1, "wrap4");
        check("wrap4.const", 32'(out_data), 32'd10);
        check("wrap4.borrow", 32'(out_borrow), 32'd1);
        step(1'b1, 4, 1'b0, 1'b1, "wrap4b");
        step(1'b1, 1, 1'b0, 1'b1, "wrap1");
        check("wrap1.const", 32'(out_data), 32'd253);
        check("wrap1.borrow", 32'(out_borrow), 32'd1);
        step(1'b0, 0, 1'b0, 1'b1, "drain3");

        // 4: fill to full with consumer stalled, then drain
        step(1'b1, 1, 1'b1, 1'b0, "full1");
        step(1'b1, 2, 1'b0, 1'b0, "full2");
        step(1'b1, 3, 1'b0, 1'b0, "full3");
        step(1'b1, 4, 1'b0, 1'b0, "full4");
        check("full.level", 32'(level), 32'd4);
        check("full.in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 5, 1'b0, 1'b0, "held5");
        check("held5.level", 32'(level), 32'd4);
        step(1'b1, 5, 1'b0, 1'b1, "pop_full");
        step(1'b1, 5, 1'b0, 1'b1, "acc5");
        repeat (4) step(1'b0, 0, 1'b0, 1'b1, "drain4");
        check("drain4.level", 32'(level), 32'd0);

        // 5: restart of an accumulation run
        step(1'b1, 100, 1'b1, 1'b0, "rs100");
        step(1'b1, 110, 1'b0, 1'b0, "rs110");
        step(1'b1, 20, 1'b1, 1'b0, "rs20");
        step(1'b1, 25, 1'b0, 1'b0, "rs25");
        step(1'b0, 0, 1'b0, 1'b1, "rsd0");
        step(1'b0, 0, 1'b0, 1'b1, "rsd1");
        check("rs20.const", 32'(out_data), 32'd20);
        check("rs20.first", 32'(out_first), 32'd1);
        step(1'b0, 0, 1'b0, 1'b1, "rsd2");
        check("rs25.const", 32'(out_data), 32'd5);
        step(1'b0, 0, 1'b0, 1'b1, "rsd3");

        // 6: asynchronous reset mid-run
        step(1'b1, 50, 1'b1, 1'b0, "mr50");
        step(1'b1, 60, 1'b0, 1'b0, "mr60");
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async.out_valid", 32'(out_valid), 32'd0);
        check("async.level", 32'(level), 32'd0);
        check("async.in_ready", 32'(in_ready), 32'd1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 40, 1'b0, 1'b1, "post40");
        check("post40.const", 32'(out_data), 32'd40);
        check("post40.first", 32'(out_first), 32'd1);
        step(1'b0, 0, 1'b0, 1'b1, "postdrain");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 6), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
